// File: rtl/alu_pkg.sv
// Shared state encoding, multiply command codes, op latencies and result-flag bit positions
// for the ALU scheduler. No logic; no latency; no backpressure.
package alu_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;

  localparam logic [1:0] LAT_STD = 2'd2;
  localparam logic [1:0] LAT_MUL = 2'd3;

  // rsp_flags layout: {err, l, g, e, cout, of}
  localparam int FLG_OF   = 0;
  localparam int FLG_COUT = 1;
  localparam int FLG_E    = 2;
  localparam int FLG_G    = 3;
  localparam int FLG_L    = 4;
  localparam int FLG_ERR  = 5;

  function automatic logic [1:0] op_lat(input logic mode, input logic [3:0] cmd);
    return (mode && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHL)) ? LAT_MUL : LAT_STD;
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Request/response bundle between two requesters (master) and alu_sched (slave).
// Requester i owns slice i of every packed req_* field; transfer = valid & ready.
interface alu_sched_if #(
  parameter int OP_LEN  = 8,
  parameter int CMD_LEN = 4
);
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0]           req_mode;
  logic [3:0]           req_in_val;
  logic [2*CMD_LEN-1:0] req_cmd;
  logic [2*OP_LEN-1:0]  req_opa;
  logic [2*OP_LEN-1:0]  req_opb;
  logic [1:0]           req_cin;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [2*OP_LEN-1:0]  rsp_res;
  logic [5:0]           rsp_flags;

  modport master (
    output req_valid, req_mode, req_in_val, req_cmd, req_opa, req_opb, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_flags
  );

  modport slave (
    input  req_valid, req_mode, req_in_val, req_cmd, req_opa, req_opb, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_res, rsp_flags
  );
endinterface

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter: grant is combinational from req, pointer moves only on adv.
// Zero latency; pointer resets to requester 1 so requester 0 wins the first contest.
module alu_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = req;
    if (&req) gnt = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last <= 1'b1;
    else if (adv) last <= gnt[1];
  end

endmodule

// File: rtl/alu_sched.sv
// Arbitrates two requesters onto one external ALU, one op in flight; RUN lasts LAT+1 cycles
// (LAT=3 multiply, else 2); result held in DONE until rsp_ready, no acceptance until IDLE.
module alu_sched
  import alu_pkg::*;
#(
  parameter int OP_LEN  = 8,
  parameter int CMD_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_sched_if.slave          bus,
  output logic                busy,
  output logic                alu_rst,
  output logic                alu_ce,
  output logic                alu_mode,
  output logic                alu_cin,
  output logic [1:0]          alu_in_val,
  output logic [CMD_LEN-1:0]  alu_cmd,
  output logic [OP_LEN-1:0]   alu_opa,
  output logic [OP_LEN-1:0]   alu_opb,
  input  logic [2*OP_LEN-1:0] alu_res,
  input  logic                alu_err,
  input  logic                alu_l,
  input  logic                alu_g,
  input  logic                alu_e,
  input  logic                alu_cout,
  input  logic                alu_of
);

  state_t              state;
  logic [1:0]          cnt;
  logic [1:0]          lat;
  logic                h_mode;
  logic                h_cin;
  logic                h_id;
  logic [1:0]          h_in_val;
  logic [CMD_LEN-1:0]  h_cmd;
  logic [OP_LEN-1:0]   h_opa;
  logic [OP_LEN-1:0]   h_opb;
  logic [2*OP_LEN-1:0] res_q;
  logic [5:0]          flags_q;
  logic [5:0]          flags_d;

  logic                idle;
  logic                run;
  logic                accept;
  logic                sel;
  logic [1:0]          gnt;
  logic                s_mode;
  logic                s_cin;
  logic [1:0]          s_in_val;
  logic [CMD_LEN-1:0]  s_cmd;
  logic [OP_LEN-1:0]   s_opa;
  logic [OP_LEN-1:0]   s_opb;

  assign idle   = (state == ST_IDLE);
  assign run    = (state == ST_RUN);
  assign accept = idle && (gnt != 2'b00);
  assign sel    = gnt[1];

  alu_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.req_valid),
    .adv   (accept),
    .gnt   (gnt)
  );

  assign s_mode   = sel ? bus.req_mode[1]   : bus.req_mode[0];
  assign s_cin    = sel ? bus.req_cin[1]    : bus.req_cin[0];
  assign s_in_val = sel ? bus.req_in_val[3:2] : bus.req_in_val[1:0];
  assign s_cmd    = sel ? bus.req_cmd[2*CMD_LEN-1:CMD_LEN] : bus.req_cmd[CMD_LEN-1:0];
  assign s_opa    = sel ? bus.req_opa[2*OP_LEN-1:OP_LEN]   : bus.req_opa[OP_LEN-1:0];
  assign s_opb    = sel ? bus.req_opb[2*OP_LEN-1:OP_LEN]   : bus.req_opb[OP_LEN-1:0];

  always_comb begin
    flags_d           = '0;
    flags_d[FLG_ERR]  = alu_err;
    flags_d[FLG_L]    = alu_l;
    flags_d[FLG_G]    = alu_g;
    flags_d[FLG_E]    = alu_e;
    flags_d[FLG_COUT] = alu_cout;
    flags_d[FLG_OF]   = alu_of;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lat      <= LAT_STD;
      h_mode   <= 1'b0;
      h_cin    <= 1'b0;
      h_id     <= 1'b0;
      h_in_val <= '0;
      h_cmd    <= '0;
      h_opa    <= '0;
      h_opb    <= '0;
      res_q    <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          h_mode   <= s_mode;
          h_cin    <= s_cin;
          h_id     <= sel;
          h_in_val <= s_in_val;
          h_cmd    <= s_cmd;
          h_opa    <= s_opa;
          h_opb    <= s_opb;
          lat      <= op_lat(s_mode, 4'(s_cmd));
          cnt      <= '0;
          state    <= ST_RUN;
        end
        // The ALU output is sampled at the edge closing cycle cnt == LAT.
        ST_RUN: if (cnt == lat) begin
          res_q   <= alu_res;
          flags_q <= flags_d;
          cnt     <= '0;
          state   <= ST_DONE;
        end else begin
          cnt <= cnt + 2'd1;
        end
        ST_DONE: if (bus.rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Ready is forced low while reset is asserted even though it is combinational.
  assign bus.req_ready = (idle && rst_n) ? gnt : 2'b00;
  assign bus.rsp_valid = (state == ST_DONE);
  assign bus.rsp_id    = h_id;
  assign bus.rsp_res   = res_q;
  assign bus.rsp_flags = flags_q;

  assign busy       = !idle;
  assign alu_rst    = ~rst_n;
  assign alu_ce     = run;
  assign alu_mode   = run & h_mode;
  assign alu_cin    = run & h_cin;
  assign alu_in_val = run ? h_in_val : '0;
  assign alu_cmd    = run ? h_cmd : '0;
  assign alu_opa    = run ? h_opa : '0;
  assign alu_opb    = run ? h_opb : '0;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched with a pipelined behavioural ALU attached and a cycle-timeline model
// of the scheduler checked on every falling edge, plus directed literal expectations.
module tb_alu_sched;
  import alu_pkg::*;

  localparam int OP_LEN  = 8;
  localparam int CMD_LEN = 4;

  typedef struct packed {
    logic [5:0]  flags;
    logic [15:0] res;
  } alu_out_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_sched_if #(.OP_LEN(OP_LEN), .CMD_LEN(CMD_LEN)) bus ();

  logic        busy, alu_rst, alu_ce, alu_mode, alu_cin;
  logic [1:0]  alu_in_val;
  logic [3:0]  alu_cmd;
  logic [7:0]  alu_opa, alu_opb;
  logic [15:0] alu_res;
  logic        alu_err, alu_l, alu_g, alu_e, alu_cout, alu_of;
  logic [23:0] drv;

  alu_sched #(.OP_LEN(OP_LEN), .CMD_LEN(CMD_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .alu_rst    (alu_rst),
    .alu_ce     (alu_ce),
    .alu_mode   (alu_mode),
    .alu_cin    (alu_cin),
    .alu_in_val (alu_in_val),
    .alu_cmd    (alu_cmd),
    .alu_opa    (alu_opa),
    .alu_opb    (alu_opb),
    .alu_res    (alu_res),
    .alu_err    (alu_err),
    .alu_l      (alu_l),
    .alu_g      (alu_g),
    .alu_e      (alu_e),
    .alu_cout   (alu_cout),
    .alu_of     (alu_of)
  );

  assign drv = {alu_mode, alu_in_val, alu_cmd, alu_opa, alu_opb, alu_cin};

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic alu_out_t alu_ref(input logic mode, input logic [1:0] iv, input logic [3:0] cmd,
                                       input logic [7:0] a, input logic [7:0] b, input logic cin);
    alu_out_t   o;
    logic [8:0] t;
    logic [7:0] x;
    o = '0;
    t = '0;
    x = '0;
    if (iv != 2'b11) begin
      o.flags[FLG_ERR] = 1'b1;
    end else if (mode) begin
      case (cmd)
        4'd0: t = {1'b0, a} + {1'b0, b};
        4'd1: t = {1'b0, a} - {1'b0, b};
        4'd2: t = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        4'd3: t = {1'b0, a} - {1'b0, b} - {8'd0, cin};
        4'd4: t = {1'b0, a} + 9'd1;
        4'd5: t = {1'b0, a} - 9'd1;
        4'd6: t = {1'b0, b} + 9'd1;
        4'd7: t = {1'b0, b} - 9'd1;
        4'd8: begin
          o.flags[FLG_E] = (a == b);
          o.flags[FLG_G] = (a > b);
          o.flags[FLG_L] = (a < b);
        end
        4'd9:  o.res = ({8'd0, a} + 16'd1) * ({8'd0, b} + 16'd1);
        4'd10: o.res = {7'd0, a, 1'b0} * {8'd0, b};
        default: o.flags[FLG_ERR] = 1'b1;
      endcase
      if (cmd < 4'd8) begin
        o.res = {8'd0, t[7:0]};
        if (cmd[0]) o.flags[FLG_OF]   = t[8];
        else        o.flags[FLG_COUT] = t[8];
      end
    end else begin
      case (cmd)
        4'd0: x = a & b;
        4'd1: x = ~(a & b);
        4'd2: x = a | b;
        4'd3: x = ~(a | b);
        4'd4: x = a ^ b;
        4'd5: x = ~(a ^ b);
        4'd6: x = ~a;
        4'd7: x = ~b;
        default: o.flags[FLG_ERR] = 1'b1;
      endcase
      o.res = {8'd0, x};
    end
    return o;
  endfunction

  // Behavioural ALU: plain ops appear two cycles after ce, multiplies three.
  alu_out_t pipe0, pipe1, pipe2, alu_o;
  always @(posedge clk or posedge alu_rst) begin
    if (alu_rst) begin
      pipe0 <= '0;
      pipe1 <= '0;
      pipe2 <= '0;
    end else begin
      pipe0 <= alu_ce ? alu_ref(alu_mode, alu_in_val, alu_cmd, alu_opa, alu_opb, alu_cin) : '0;
      pipe1 <= pipe0;
      pipe2 <= pipe1;
    end
  end
  assign alu_o    = (alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10)) ? pipe2 : pipe1;
  assign alu_res  = alu_o.res;
  assign alu_err  = alu_o.flags[FLG_ERR];
  assign alu_l    = alu_o.flags[FLG_L];
  assign alu_g    = alu_o.flags[FLG_G];
  assign alu_e    = alu_o.flags[FLG_E];
  assign alu_cout = alu_o.flags[FLG_COUT];
  assign alu_of   = alu_o.flags[FLG_OF];

  // Timeline model: an accepted op is in RUN for ages 0..lat, then in DONE until rsp_ready.
  bit          m_busy = 1'b0;
  bit          m_last = 1'b1;
  int          m_age  = 0;
  int          m_lat  = 2;
  logic        m_id   = 1'b0;
  logic [1:0]  m_v, m_gnt;
  logic [23:0] m_drive = '0;
  alu_out_t    m_exp = '0;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ctrl", 64'({busy, alu_ce, bus.rsp_valid, bus.rsp_id, bus.req_ready}), 64'd0);
        chk("rst_drive", 64'(drv), 64'd0);
        chk("rst_rsp", 64'({bus.rsp_flags, bus.rsp_res}), 64'd0);
        chk("rst_alu_rst", 64'(alu_rst), 64'd1);
        m_busy = 1'b0;
        m_last = 1'b1;
      end else begin
        m_v   = bus.req_valid;
        m_gnt = (m_v == 2'b11) ? (m_last ? 2'b01 : 2'b10) : m_v;
        if (!m_busy) begin
          chk("idle_ctrl", 64'({busy, alu_ce, bus.rsp_valid}), 64'd0);
          chk("idle_drive", 64'(drv), 64'd0);
          chk("idle_req_ready", 64'(bus.req_ready), 64'(m_gnt));
        end else if (m_age <= m_lat) begin
          chk("run_ctrl", 64'({busy, alu_ce, bus.rsp_valid, bus.req_ready}), 64'b11000);
          chk("run_drive", 64'(drv), 64'(m_drive));
        end else begin
          chk("done_ctrl", 64'({busy, alu_ce, bus.rsp_valid, bus.req_ready}), 64'b10100);
          chk("done_id", 64'(bus.rsp_id), 64'(m_id));
          chk("done_res", 64'(bus.rsp_res), 64'(m_exp.res));
          chk("done_flags", 64'(bus.rsp_flags), 64'(m_exp.flags));
        end
        if (!m_busy) begin
          if (m_gnt != 2'b00) begin
            m_id = m_gnt[1];
            if (m_id)
              m_drive = {bus.req_mode[1], bus.req_in_val[3:2], bus.req_cmd[7:4],
                         bus.req_opa[15:8], bus.req_opb[15:8], bus.req_cin[1]};
            else
              m_drive = {bus.req_mode[0], bus.req_in_val[1:0], bus.req_cmd[3:0],
                         bus.req_opa[7:0], bus.req_opb[7:0], bus.req_cin[0]};
            m_last = m_id;
            m_busy = 1'b1;
            m_age  = 0;
            m_lat  = (m_drive[23] && (m_drive[20:17] == 4'd9 || m_drive[20:17] == 4'd10)) ? 3 : 2;
            m_exp  = alu_ref(m_drive[23], m_drive[22:21], m_drive[20:17],
                             m_drive[16:9], m_drive[8:1], m_drive[0]);
          end
        end else if (m_age > m_lat && bus.rsp_ready) begin
          m_busy = 1'b0;
        end else begin
          m_age++;
        end
      end
    end
  end

  task automatic set_fields(input bit i, input logic mode, input logic [1:0] iv, input logic [3:0] cmd,
                            input logic [7:0] a, input logic [7:0] b, input logic cin);
    if (i) begin
      bus.req_mode[1] = mode;  bus.req_in_val[3:2] = iv; bus.req_cmd[7:4] = cmd;
      bus.req_opa[15:8] = a;   bus.req_opb[15:8] = b;    bus.req_cin[1] = cin;
    end else begin
      bus.req_mode[0] = mode;  bus.req_in_val[1:0] = iv; bus.req_cmd[3:0] = cmd;
      bus.req_opa[7:0] = a;    bus.req_opb[7:0] = b;     bus.req_cin[0] = cin;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input bit i, input logic mode, input logic [1:0] iv, input logic [3:0] cmd,
                       input logic [7:0] a, input logic [7:0] b, input logic cin);
    bit ok;
    ok = 1'b0;
    set_fields(i, mode, iv, cmd, a, b, cin);
    bus.req_valid[i] = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.req_valid[i] = 1'b0;
    chk("accept_timeout", 64'(ok), 64'd1);
  endtask

  // Returns on the falling edge of the first DONE cycle; run = cycles seen before it.
  task automatic wait_rsp(output int run);
    bit ok;
    ok  = 1'b0;
    run = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) ok = 1'b1;
      else run++;
    end
    chk("rsp_timeout", 64'(ok), 64'd1);
  endtask

  initial begin : stim
    int   run;
    logic ids [4];
    bus.req_valid  = '0;
    bus.req_mode   = '0;
    bus.req_in_val = '0;
    bus.req_cmd    = '0;
    bus.req_opa    = '0;
    bus.req_opb    = '0;
    bus.req_cin    = '0;
    bus.rsp_ready  = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both requesters held valid: strict alternation starting at requester 0.
    set_fields(1'b0, 1'b1, 2'd3, 4'd0, 8'd1, 8'd2, 1'b0);
    set_fields(1'b1, 1'b0, 2'd3, 4'd4, 8'h55, 8'h0F, 1'b0);
    bus.req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_rsp(run);
      ids[n] = bus.rsp_id;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 2'b00;
    chk("rr_grant0", 64'(ids[0]), 64'd0);
    chk("rr_grant1", 64'(ids[1]), 64'd1);
    chk("rr_grant2", 64'(ids[2]), 64'd0);
    chk("rr_grant3", 64'(ids[3]), 64'd1);

    issue(1'b0, 1'b1, 2'd3, 4'd0, 8'd10, 8'd20, 1'b0);
    wait_rsp(run);
    chk("add_res", 64'(bus.rsp_res), 64'd30);
    chk("add_id", 64'(bus.rsp_id), 64'd0);
    chk("add_run_cycles", 64'(run), 64'd3);
    @(posedge clk);
    #1;

    issue(1'b1, 1'b1, 2'd3, 4'd9, 8'd3, 8'd4, 1'b0);
    wait_rsp(run);
    chk("mul_res", 64'(bus.rsp_res), 64'd20);
    chk("mul_id", 64'(bus.rsp_id), 64'd1);
    chk("mul_run_cycles", 64'(run), 64'd4);
    @(posedge clk);
    #1;

    issue(1'b0, 1'b1, 2'd3, 4'd8, 8'd5, 8'd5, 1'b0);
    wait_rsp(run);
    chk("cmp_flags", 64'(bus.rsp_flags), 64'b000100);
    @(posedge clk);
    #1;

    issue(1'b1, 1'b1, 2'd1, 4'd0, 8'd7, 8'd7, 1'b0);
    wait_rsp(run);
    chk("illegal_res", 64'(bus.rsp_res), 64'd0);
    chk("illegal_flags", 64'(bus.rsp_flags), 64'b100000);
    @(posedge clk);
    #1;

    // Response held off; a request from 1 arrives and is withdrawn meanwhile.
    bus.rsp_ready = 1'b0;
    issue(1'b0, 1'b0, 2'd3, 4'd4, 8'hF0, 8'hFF, 1'b0);
    wait_rsp(run);
    chk("xor_res", 64'(bus.rsp_res), 64'h0F);
    set_fields(1'b1, 1'b1, 2'd3, 4'd0, 8'd1, 8'd1, 1'b0);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      if (n == 0) bus.req_valid[1] = 1'b1;
      @(negedge clk);
      chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_res", 64'(bus.rsp_res), 64'h0F);
      chk("hold_busy_ready", 64'({busy, bus.req_ready}), 64'b100);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply: aborted, nothing emerges afterwards.
    issue(1'b0, 1'b1, 2'd3, 4'd10, 8'd6, 8'd7, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", 64'({busy, alu_ce, bus.rsp_valid, bus.req_ready}), 64'd0);
    chk("abort_drive", 64'(drv), 64'd0);
    chk("abort_alu_rst", 64'(alu_rst), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("post_abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    issue(1'b0, 1'b1, 2'd3, 4'd10, 8'd6, 8'd7, 1'b0);
    wait_rsp(run);
    chk("shl_mul_res", 64'(bus.rsp_res), 64'd84);
    chk("shl_mul_id", 64'(bus.rsp_id), 64'd0);
    chk("shl_mul_run_cycles", 64'(run), 64'd4);
    @(posedge clk);
    #1;

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameters: OP_LEN, 8, ALU operand width; CMD_LEN, 4, ALU command width.
REQ-002 clk  in  1  single clock; all flops rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 req_valid[1:0]  in  2  per-requester operation request.
REQ-005 req_ready[1:0]  out  2  per-requester accept; transfer = valid & ready.
REQ-006 req_mode[1:0], req_in_val[3:0], req_cmd[2*CMD_LEN-1:0], req_opa/req_opb[2*OP_LEN-1:0], req_cin[1:0]  in  packed per requester (requester i = slice i)  operation fields.
REQ-007 rsp_valid  out  1  result available; rsp_ready  in  1  result consumed.
REQ-008 rsp_id  out  1  requester owning the result.
REQ-009 rsp_res  out  2*OP_LEN  captured ALU result.
REQ-010 rsp_flags  out  6  {err,l,g,e,cout,of} captured.
REQ-011 alu_ce, alu_mode, alu_cin  out  1 each; alu_in_val  out  2; alu_cmd  out  CMD_LEN; alu_opa/alu_opb  out  OP_LEN  ALU drive.
REQ-012 alu_rst  out  1  active-high ALU reset = ~rst_n, combinational.
REQ-013 alu_res  in  2*OP_LEN; alu_err, alu_l, alu_g, alu_e, alu_cout, alu_of  in  1 each  ALU outputs.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, RUN, DONE; one operation in flight at a time.
REQ-016 IDLE: req_ready[i] = 1 only for the arbitration winner i, combinational from req_valid and rr pointer; acceptance moves to RUN.
REQ-017 Round-robin: both valid -> grant requester not granted last; one valid -> grant it; pointer updates only on acceptance.
REQ-018 On acceptance, register mode, in_val, cmd, opa, opb, cin and id; hold on alu_* unchanged for all of RUN.
REQ-019 Latency LAT = 3 when mode=1 and cmd in {9,10} (multiply); else LAT = 2.
REQ-020 RUN: alu_ce=1; counter cnt starts 0 at first RUN cycle, increments per cycle; at edge ending cycle cnt==LAT, capture alu_res and flags, go DONE (RUN lasts LAT+1 cycles).
REQ-021 alu_ce=0 in IDLE and DONE; alu_* operand/command outputs are 0 in IDLE.
REQ-022 DONE: rsp_valid=1, rsp_* stable until rsp_ready=1; then IDLE next cycle; no new acceptance in the DONE cycle.
REQ-023 rsp_ready while rsp_valid=0 ignored; req_valid dropped before acceptance withdraws request with no effect.
REQ-024 Minimum accept-to-accept spacing: LAT+3 cycles with rsp_ready held high.
REQ-025 Controller does not validate cmd/in_val; illegal combinations are passed through and the ALU result (0) returned.

Reset
REQ-026 rst_n low asynchronously: state IDLE, cnt 0, rr pointer = 1 (requester 0 wins first), all held fields 0, all outputs 0 except alu_rst=1.
REQ-027 Reset mid-RUN or mid-DONE aborts the operation; no response is produced after release.

Structure
REQ-028 Shared package alu_pkg: state enum, command constants (CMD_MUL_INC=9, CMD_MUL_SHL=10), LAT_STD=2, LAT_MUL=3, flag bit positions.
REQ-029 One sub-module: alu_rr_arb (2-way round-robin arbiter, req in, grant out, advance strobe); ALU instanced at top level, not inside alu_sched.

Verification (bench with real ALU connected)
REQ-030 Req0 mode=1 in_val=3 cmd=0 opa=10 opb=20 -> accept, rsp_valid 3 cycles later, rsp_res=30, rsp_id=0.
REQ-031 Req1 mode=1 in_val=3 cmd=9 opa=3 opb=4 -> rsp_res=20 after 4 RUN cycles, rsp_id=1.
REQ-032 Both valid continuously, rsp_ready=1 -> grant order 0,1,0,1; no requester starved.
REQ-033 Req0 mode=0 in_val=3 cmd=4 opa=0xF0 opb=0xFF, rsp_ready low 5 cycles -> rsp_res=0x0F held stable, busy=1, req_ready=0 throughout.
REQ-034 rst_n low during RUN of multiply -> all outputs 0 immediately, alu_rst=1; after release no rsp_valid, next request served normally.
REQ-035 Req0 mode=1 in_val=3 cmd=8 opa=5 opb=5 -> rsp_flags e=1, l=g=0.
